// File: rtl/oq_drr_scheduler.sv
// -----------------------------------------------------------------------------
// oq_drr_scheduler
//
// Deficit-round-robin arbiter that chooses which output queue the SRAM packet
// remover drains next. Each queue earns its programmable quantum (in SRAM
// words) once per visit of the pointer. It may send head packets for as long
// as the head length fits inside its accumulated deficit. Only one grant is
// outstanding at a time.
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   oq_empty         per queue, 1 = queue holds no packet
//   enable_send_pkt  per queue, 1 = queue may be scheduled
//   tx_fifo_empty    per queue, 1 = tx fifo can absorb a full packet
//   head_pkt_words   packed head-packet lengths, queue i at [i*PKT_WORDS_WIDTH +: PKT_WORDS_WIDTH]
//   quantum          packed per-queue quanta, queue i at [i*QUANTUM_WIDTH +: QUANTUM_WIDTH]
//   sched_vld        grant valid (held until sched_rdy)
//   sched_oq         granted queue index
//   sched_rdy        remover accepts the grant
//   pkt_done         one-cycle pulse, granted packet fully removed
//   cur_deficit      deficit of the queue under the pointer (readback)
// -----------------------------------------------------------------------------
module oq_drr_scheduler #(
  parameter int NUM_OUTPUT_QUEUES = 4,
  parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
  parameter int PKT_WORDS_WIDTH   = 8,
  parameter int QUANTUM_WIDTH     = 10,
  parameter int DEFICIT_WIDTH     = 11
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [NUM_OUTPUT_QUEUES-1:0]                 oq_empty,
  input  logic [NUM_OUTPUT_QUEUES-1:0]                 enable_send_pkt,
  input  logic [NUM_OUTPUT_QUEUES-1:0]                 tx_fifo_empty,
  input  logic [NUM_OUTPUT_QUEUES*PKT_WORDS_WIDTH-1:0] head_pkt_words,
  input  logic [NUM_OUTPUT_QUEUES*QUANTUM_WIDTH-1:0]   quantum,
  output logic                                         sched_vld,
  output logic [NUM_OQ_WIDTH-1:0]                      sched_oq,
  input  logic                                         sched_rdy,
  input  logic                                         pkt_done,
  output logic [DEFICIT_WIDTH-1:0]                     cur_deficit
);

  typedef enum logic [1:0] {
    SEL   = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam logic [NUM_OQ_WIDTH-1:0] LAST_OQ = NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);

  // Deficit + quantum, clamped at the counter's all-ones value instead of
  // wrapping, so a long-starved queue never loses its credit.
  function automatic logic [DEFICIT_WIDTH-1:0] sat_add(
    input logic [DEFICIT_WIDTH-1:0] d,
    input logic [QUANTUM_WIDTH-1:0] q
  );
    logic [DEFICIT_WIDTH:0] sum;
    sum = {1'b0, d} + (DEFICIT_WIDTH+1)'(q);
    if (sum[DEFICIT_WIDTH]) begin
      sat_add = '1;
    end else begin
      sat_add = sum[DEFICIT_WIDTH-1:0];
    end
  endfunction

  // Deficit minus the granted packet length. The grant compare guarantees
  // len <= d, so this never underflows.
  function automatic logic [DEFICIT_WIDTH-1:0] spend(
    input logic [DEFICIT_WIDTH-1:0]   d,
    input logic [PKT_WORDS_WIDTH-1:0] len
  );
    spend = d - DEFICIT_WIDTH'(len);
  endfunction

  function automatic logic [NUM_OQ_WIDTH-1:0] ptr_step(input logic [NUM_OQ_WIDTH-1:0] p);
    if (p == LAST_OQ) begin
      ptr_step = '0;
    end else begin
      ptr_step = p + 1'b1;
    end
  endfunction

  // Unpacked views of the packed per-queue buses
  logic [PKT_WORDS_WIDTH-1:0] head_a    [NUM_OUTPUT_QUEUES];
  logic [QUANTUM_WIDTH-1:0]   quantum_a [NUM_OUTPUT_QUEUES];

  for (genvar g = 0; g < NUM_OUTPUT_QUEUES; g++) begin : g_unpack
    assign head_a[g]    = head_pkt_words[g*PKT_WORDS_WIDTH +: PKT_WORDS_WIDTH];
    assign quantum_a[g] = quantum[g*QUANTUM_WIDTH +: QUANTUM_WIDTH];
  end

  state_t                     state, state_nxt;
  logic [NUM_OQ_WIDTH-1:0]    ptr, ptr_nxt;
  logic                       fresh, fresh_nxt;
  logic                       vld_nxt;
  logic [NUM_OQ_WIDTH-1:0]    oq_nxt;
  logic [PKT_WORDS_WIDTH-1:0] hw, hw_nxt;
  logic [DEFICIT_WIDTH-1:0]   deficit [NUM_OUTPUT_QUEUES];
  logic                       def_we;
  logic [DEFICIT_WIDTH-1:0]   def_wdata;
  logic [DEFICIT_WIDTH-1:0]   def_ptr;
  logic [DEFICIT_WIDTH-1:0]   head_ext;

  assign def_ptr     = deficit[ptr];
  assign head_ext    = DEFICIT_WIDTH'(head_a[ptr]);
  assign cur_deficit = def_ptr;

  // Next-state and datapath decisions. Only the queue under the pointer is
  // ever inspected or written, so the deficit file has a single write port.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    fresh_nxt = fresh;
    vld_nxt   = sched_vld;
    oq_nxt    = sched_oq;
    hw_nxt    = hw;
    def_we    = 1'b0;
    def_wdata = def_ptr;

    unique case (state)
      SEL: begin
        if (oq_empty[ptr]) begin
          // An idle queue forfeits its credit
          def_we    = 1'b1;
          def_wdata = '0;
          ptr_nxt   = ptr_step(ptr);
          fresh_nxt = 1'b1;
        end else if (!enable_send_pkt[ptr] || !tx_fifo_empty[ptr]) begin
          ptr_nxt   = ptr_step(ptr);
          fresh_nxt = 1'b1;
        end else if (fresh) begin
          // First eligible cycle of a visit: earn the quantum, compare next cycle
          def_we    = 1'b1;
          def_wdata = sat_add(def_ptr, quantum_a[ptr]);
          fresh_nxt = 1'b0;
        end else if (head_ext <= def_ptr) begin
          hw_nxt    = head_a[ptr];
          oq_nxt    = ptr;
          vld_nxt   = 1'b1;
          state_nxt = GRANT;
        end else begin
          ptr_nxt   = ptr_step(ptr);
          fresh_nxt = 1'b1;
        end
      end

      GRANT: begin
        // The length latched at grant time is charged; live inputs are ignored
        if (sched_rdy) begin
          vld_nxt   = 1'b0;
          def_we    = 1'b1;
          def_wdata = spend(def_ptr, hw);
          state_nxt = BUSY;
        end
      end

      BUSY: begin
        // Return to the same queue without a new quantum so it spends its
        // remaining deficit before the pointer moves on
        if (pkt_done) begin
          state_nxt = SEL;
          fresh_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = SEL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEL;
      ptr       <= '0;
      fresh     <= 1'b1;
      sched_vld <= 1'b0;
      sched_oq  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      fresh     <= fresh_nxt;
      sched_vld <= vld_nxt;
      sched_oq  <= oq_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
        deficit[i] <= '0;
      end
    end else if (def_we) begin
      deficit[ptr] <= def_wdata;
    end
  end

  // Granted length is only consumed in GRANT, after being written in SEL
  always_ff @(posedge clk) begin
    hw <= hw_nxt;
  end

  a_grant_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (sched_vld && !sched_rdy) |=> (sched_vld && $stable(sched_oq)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    (state == GRANT && sched_rdy) |-> (DEFICIT_WIDTH'(hw) <= def_ptr));

endmodule

// File: tb/tb_oq_drr_scheduler.sv
module tb_oq_drr_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  oq_empty;
  logic [3:0]  enable_send_pkt;
  logic [3:0]  tx_fifo_empty;
  logic [31:0] head_pkt_words;
  logic [39:0] quantum;
  logic        sched_vld;
  logic [1:0]  sched_oq;
  logic        sched_rdy;
  logic        pkt_done;
  logic [10:0] cur_deficit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oq_drr_scheduler dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .oq_empty        (oq_empty),
    .enable_send_pkt (enable_send_pkt),
    .tx_fifo_empty   (tx_fifo_empty),
    .head_pkt_words  (head_pkt_words),
    .quantum         (quantum),
    .sched_vld       (sched_vld),
    .sched_oq        (sched_oq),
    .sched_rdy       (sched_rdy),
    .pkt_done        (pkt_done),
    .cur_deficit     (cur_deficit)
  );

  typedef struct {
    int q;          // quantum of q1
    int h;          // head length of q1
    int t_grant;    // edge after release where sched_vld is first seen (0 = never)
    int def_after;  // deficit of q1 right after the grant is accepted
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input int q, input logic [7:0] v);
    head_pkt_words[q*8 +: 8] = v;
  endtask

  task automatic set_quant(input int q, input logic [9:0] v);
    quantum[q*10 +: 10] = v;
  endtask

  // Holds reset for 3 edges, checks reset values, releases 1 ns after an edge
  task automatic do_reset();
    reset_n   = 1'b0;
    sched_rdy = 1'b0;
    pkt_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vld", int'(sched_vld), 0);
    chk("reset_oq", int'(sched_oq), 0);
    chk("reset_deficit", int'(cur_deficit), 0);
    reset_n = 1'b1;
  endtask

  task automatic accept();
    sched_rdy = 1'b1;
    tick();
    sched_rdy = 1'b0;
  endtask

  task automatic done_pulse();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
  endtask

  int got;
  int cnt[4];
  int seen_vld;

  initial begin
    reset_n         = 1'b0;
    oq_empty        = 4'hF;
    enable_send_pkt = 4'hF;
    tx_fifo_empty   = 4'hF;
    head_pkt_words  = '0;
    quantum         = '0;
    sched_rdy       = 1'b0;
    pkt_done        = 1'b0;

    tbl[0] = '{q: 16,   h: 10,  t_grant: 3, def_after: 6};
    tbl[1] = '{q: 16,   h: 16,  t_grant: 3, def_after: 0};
    tbl[2] = '{q: 16,   h: 17,  t_grant: 8, def_after: 15};
    tbl[3] = '{q: 0,    h: 5,   t_grant: 0, def_after: 0};
    tbl[4] = '{q: 1023, h: 255, t_grant: 3, def_after: 768};
    tbl[5] = '{q: 100,  h: 150, t_grant: 8, def_after: 50};

    // All queues empty: nothing is ever granted
    do_reset();
    seen_vld = 0;
    repeat (12) begin
      tick();
      if (sched_vld) seen_vld = 1;
    end
    chk("idle_no_grant", seen_vld, 0);

    // Table: q1 alone with various quantum/head combinations
    for (int i = 0; i < 6; i++) begin
      oq_empty = 4'b1101;
      set_quant(1, 10'(tbl[i].q));
      set_head(1, 8'(tbl[i].h));
      do_reset();
      got = 0;
      for (int t = 1; t <= 40; t++) begin
        tick();
        if (sched_vld) begin
          got = t;
          break;
        end
      end
      chk($sformatf("vec%0d_grant_cycle", i), got, tbl[i].t_grant);
      if (got != 0) begin
        chk($sformatf("vec%0d_oq", i), int'(sched_oq), 1);
        accept();
        chk($sformatf("vec%0d_vld_drop", i), int'(sched_vld), 0);
        chk($sformatf("vec%0d_deficit", i), int'(cur_deficit), tbl[i].def_after);
        done_pulse();
      end
    end

    // Single queue: leftover deficit kept, back-to-back, tx skip, reset in BUSY
    oq_empty = 4'b1101;
    set_quant(1, 10'd16);
    set_head(1, 8'd10);
    do_reset();
    repeat (3) tick();
    chk("sq_vld", int'(sched_vld), 1);
    chk("sq_oq", int'(sched_oq), 1);
    accept();
    chk("sq_def6", int'(cur_deficit), 6);
    done_pulse();
    tick();
    chk("sq_moved_to_q2", int'(cur_deficit), 0);
    repeat (3) tick();
    chk("sq_def_kept", int'(cur_deficit), 6);
    tick();
    chk("sq_def_added", int'(cur_deficit), 22);
    tick();
    chk("sq_regrant", int'(sched_vld), 1);
    accept();
    chk("sq_def12", int'(cur_deficit), 12);
    done_pulse();
    tick();
    chk("sq_back_to_back", int'(sched_vld), 1);
    accept();
    chk("sq_def2", int'(cur_deficit), 2);
    tx_fifo_empty[1] = 1'b0;
    done_pulse();
    seen_vld = 0;
    repeat (8) begin
      tick();
      if (sched_vld) seen_vld = 1;
    end
    chk("skip_no_grant", seen_vld, 0);
    chk("skip_def_kept", int'(cur_deficit), 2);
    tx_fifo_empty[1] = 1'b1;
    tick();
    chk("skip_then_add", int'(cur_deficit), 18);
    tick();
    chk("skip_then_grant", int'(sched_vld), 1);
    accept();
    chk("busy_def8", int'(cur_deficit), 8);
    reset_n = 1'b0;
    #1;
    chk("async_rst_vld", int'(sched_vld), 0);
    chk("async_rst_oq", int'(sched_oq), 0);
    chk("async_rst_def", int'(cur_deficit), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_cleared_q1_def", int'(cur_deficit), 0);
    repeat (2) tick();
    chk("rst_no_done_wait", int'(sched_vld), 1);
    accept();
    done_pulse();

    // Handshake hold and pkt_done ignored outside BUSY
    oq_empty = 4'b1110;
    set_quant(0, 10'd16);
    set_head(0, 8'd10);
    do_reset();
    repeat (2) tick();
    chk("hold_vld", int'(sched_vld), 1);
    chk("hold_oq", int'(sched_oq), 0);
    set_head(0, 8'd4);
    for (int k = 0; k < 5; k++) begin
      oq_empty[0] = ~oq_empty[0];
      tick();
      chk($sformatf("hold_stable%0d", k), int'({sched_vld, sched_oq}), 4);
    end
    oq_empty[0] = 1'b0;
    done_pulse();
    chk("done_in_grant_ignored", int'(sched_vld), 1);
    sched_rdy = 1'b1;
    pkt_done  = 1'b1;
    tick();
    sched_rdy = 1'b0;
    pkt_done  = 1'b0;
    chk("hold_accept_vld", int'(sched_vld), 0);
    chk("hold_latched_len", int'(cur_deficit), 6);
    seen_vld = 0;
    repeat (3) begin
      tick();
      if (sched_vld) seen_vld = 1;
    end
    chk("busy_waits_done", seen_vld, 0);
    done_pulse();
    tick();
    chk("after_done_grant", int'(sched_vld), 1);
    chk("after_done_oq", int'(sched_oq), 0);
    accept();
    done_pulse();

    // Empty queue forfeits accumulated deficit
    oq_empty = 4'b0111;
    set_quant(3, 10'd30);
    set_head(3, 8'd40);
    do_reset();
    repeat (4) tick();
    chk("empty_acc30", int'(cur_deficit), 30);
    tick();
    oq_empty[3] = 1'b1;
    repeat (3) tick();
    chk("empty_before_visit", int'(cur_deficit), 30);
    repeat (4) tick();
    chk("empty_zeroed", int'(cur_deficit), 0);
    chk("empty_no_grant", int'(sched_vld), 0);

    // DRR fairness: q0 quantum 64, q2 quantum 128, 64-word packets
    oq_empty = 4'b1010;
    set_quant(0, 10'd64);
    set_quant(2, 10'd128);
    set_head(0, 8'd64);
    set_head(2, 8'd64);
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int p = 0; p < 40; p++) begin
      got = 0;
      for (int t = 0; t < 50; t++) begin
        tick();
        if (sched_vld) begin
          got = 1;
          break;
        end
      end
      if (got == 0) begin
        chk("fair_timeout", got, 1);
        break;
      end
      cnt[sched_oq]++;
      accept();
      done_pulse();
    end
    chk("fair_q0", cnt[0], 14);
    chk("fair_q2", cnt[2], 26);

    // Saturation: earn 1023 per visit, toggle enable so the grant never fires
    oq_empty = 4'b1101;
    set_quant(1, 10'd1023);
    set_head(1, 8'd255);
    enable_send_pkt[1] = 1'b0;
    do_reset();
    seen_vld = 0;
    for (int t = 1; t <= 17; t++) begin
      enable_send_pkt[1] = ((t % 5) == 2);
      tick();
      if (sched_vld) seen_vld = 1;
      if (t == 7)  chk("sat_2046", int'(cur_deficit), 2046);
      if (t == 12) chk("sat_clamp", int'(cur_deficit), 2047);
      if (t == 17) chk("sat_hold", int'(cur_deficit), 2047);
    end
    chk("sat_no_grant", seen_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
